// File: rtl/rst_seq_ctr.sv
// Staged reset sequencer: qualifies MMCM lock, then releases N_STAGE resets in order.
// Optional macro RST_SEQ_LOCK_CNT_EN builds the saturating lock-loss event counter.
module rst_seq_ctr #(
  parameter int N_STAGE         = 4,
  parameter int LOCK_STABLE_CYC = 1024,
  parameter int STAGE_GAP       = 16,
  parameter int SOFT_HOLD       = 64
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               mmc_lock,
  input  logic               soft_rst_req,
  output logic [N_STAGE-1:0] rst_stage,
  output logic               seq_done,
  output logic [2:0]         seq_state,
  output logic [7:0]         lock_lost_cnt
);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    SOFT      = 3'd4
  } state_t;

  localparam logic [15:0] LOCK_LAST = 16'(LOCK_STABLE_CYC - 1);
  localparam logic [15:0] GAP_LAST  = 16'(STAGE_GAP - 1);
  localparam logic [15:0] SOFT_LAST = 16'(SOFT_HOLD - 1);
  localparam logic [2:0]  IDX_LAST  = 3'(N_STAGE - 1);

  function automatic logic [N_STAGE-1:0] stage_mask(input logic [2:0] idx);
    logic [N_STAGE-1:0] m;
    m = '0;
    for (int i = 0; i < N_STAGE; i++)
      if (idx == 3'(i)) m[i] = 1'b1;
    return m;
  endfunction

  logic lock_p0, lock_p1, lock_p2;
  logic lock_s, lock_q;

  // Stage p0/p1: two-flop synchronizer for mmc_lock; p2 is a one-cycle history of lock_s
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      lock_p0 <= 1'b0;
      lock_p1 <= 1'b0;
      lock_p2 <= 1'b0;
    end else begin
      lock_p0 <= mmc_lock;
      lock_p1 <= lock_p0;
      lock_p2 <= lock_p1;
    end
  end

  assign lock_s = lock_p1;
  // Qualification starts only once lock_s has been high on two consecutive cycles.
  assign lock_q = lock_p1 & lock_p2;

  state_t             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [N_STAGE-1:0] stage_q, stage_d;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      stage_q <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    case (state_q)
      WAIT_LOCK: begin
        stage_d = '1;
        cnt_d   = 16'd0;
        if (lock_q) state_d = STABLE;
      end
      STABLE: begin
        stage_d = '1;
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = 16'd0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = RELEASE;
          cnt_d   = 16'd0;
          idx_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RELEASE, RUN: begin
        // Lock loss takes priority over a simultaneous soft request.
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          stage_d = '1;
          cnt_d   = 16'd0;
          idx_d   = 3'd0;
        end else if (soft_rst_req) begin
          state_d = SOFT;
          stage_d = '1;
          cnt_d   = 16'd0;
          idx_d   = 3'd0;
        end else if (state_q == RELEASE) begin
          if (cnt_q == GAP_LAST) begin
            stage_d = stage_q & ~stage_mask(idx_q);
            cnt_d   = 16'd0;
            idx_d   = idx_q + 3'd1;
            if (idx_q == IDX_LAST) state_d = RUN;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      SOFT: begin
        stage_d = '1;
        if (cnt_q == SOFT_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        stage_d = '1;
        cnt_d   = 16'd0;
        idx_d   = 3'd0;
      end
    endcase
  end

  assign rst_stage = stage_q;
  assign seq_done  = (state_q == RUN);
  assign seq_state = state_q;

`ifdef RST_SEQ_LOCK_CNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic       lost_evt;
  logic [7:0] lost_cnt_q;

  assign lost_evt = ((state_q == RELEASE) || (state_q == RUN)) && !lock_s;

  always_ff @(posedge sys_clk) begin
    if (sys_rst)       lost_cnt_q <= 8'd0;
    else if (lost_evt) lost_cnt_q <= sat_inc8(lost_cnt_q);
  end

  assign lock_lost_cnt = lost_cnt_q;
`else
  assign lock_lost_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_rst_seq_ctr.sv
// Self-checking bench for rst_seq_ctr: directed scenarios plus randomized lock/soft/reset
// traffic against a time-based reference model; a second small-parameter instance covers counter saturation.
module tb_rst_seq_ctr;

  localparam int L  = 1024;
  localparam int G  = 16;
  localparam int N  = 4;
  localparam int SH = 64;

`ifdef RST_SEQ_LOCK_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst, mmc_lock, soft_rst_req;
  logic [3:0] rst_stage;
  logic       seq_done;
  logic [2:0] seq_state;
  logic [7:0] lock_lost_cnt;

  logic       sm_rst, sm_lock, sm_soft;
  logic [1:0] sm_stage;
  logic       sm_done;
  logic [2:0] sm_state;
  logic [7:0] sm_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 sys_clk = ~sys_clk;

  rst_seq_ctr dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .mmc_lock(mmc_lock), .soft_rst_req(soft_rst_req),
    .rst_stage(rst_stage), .seq_done(seq_done), .seq_state(seq_state), .lock_lost_cnt(lock_lost_cnt)
  );

  rst_seq_ctr #(.N_STAGE(2), .LOCK_STABLE_CYC(2), .STAGE_GAP(2), .SOFT_HOLD(2)) dut_sm (
    .sys_clk(sys_clk), .sys_rst(sm_rst), .mmc_lock(sm_lock), .soft_rst_req(sm_soft),
    .rst_stage(sm_stage), .seq_done(sm_done), .seq_state(sm_state), .lock_lost_cnt(sm_cnt)
  );

  // Reference model: mode 0 = waiting for lock, 1 = sequencing since m_start, 2 = soft hold since m_soft.
  int now = 0;
  int m_mode = 0;
  int m_start = 0;
  int m_soft = 0;
  int m_lost = 0;
  bit m_s1 = 1'b0, m_s2 = 1'b0, m_s3 = 1'b0;

  task automatic model_step();
    int e;
    now++;
    if (sys_rst) begin
      m_mode = 0; m_lost = 0;
      m_s1 = 1'b0; m_s2 = 1'b0; m_s3 = 1'b0;
    end else begin
      e = now - m_start;
      case (m_mode)
        0: if (m_s2 && m_s3) begin m_mode = 1; m_start = now; end
        1: begin
          if (!m_s2) begin
            m_mode = 0;
            if (e > L) m_lost = (m_lost < 255) ? m_lost + 1 : 255;
          end else if (soft_rst_req && e > L) begin
            m_mode = 2; m_soft = now;
          end
        end
        default: if (now - m_soft == SH) m_mode = 0;
      endcase
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = mmc_lock;
    end
  endtask

  task automatic model_out(output logic [3:0] st, output logic dn, output logic [2:0] ss);
    int e;
    st = 4'hF; dn = 1'b0;
    ss = (m_mode == 2) ? 3'd4 : 3'd0;
    if (m_mode == 1) begin
      e = now - m_start;
      if (e < L) ss = 3'd1;
      else begin
        for (int i = 0; i < N; i++)
          if (e >= L + (i + 1) * G) st[i] = 1'b0;
        dn = (e >= L + N * G);
        ss = dn ? 3'd3 : 3'd2;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, now);
    end
  endtask

  task automatic check_all();
    logic [3:0] st;
    logic       dn;
    logic [2:0] ss;
    model_out(st, dn, ss);
    check("model_rst_stage", 32'(rst_stage), 32'(st));
    check("model_seq_done", 32'(seq_done), 32'(dn));
    check("model_seq_state", 32'(seq_state), 32'(ss));
    check("model_lost_cnt", 32'(lock_lost_cnt), CNT_EN ? 32'(m_lost) : 32'd0);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_stage"}, 32'(rst_stage), 32'hF);
    check({tag, "_done"}, 32'(seq_done), 32'd0);
    check({tag, "_state"}, 32'(seq_state), 32'd0);
    check({tag, "_cnt"}, 32'(lock_lost_cnt), 32'd0);
  endtask

  initial begin
    int exp_sm;
    sys_rst = 1'b1; mmc_lock = 1'b0; soft_rst_req = 1'b0;
    sm_rst = 1'b1; sm_lock = 1'b0; sm_soft = 1'b0;

    // Power-up: reset for 10 cycles, then lock held high (first tick below is E0).
    repeat (10) tick();
    check_reset_vals("por");
    sys_rst = 1'b0; mmc_lock = 1'b1;
    for (int k = 0; k <= 1095; k++) begin
      tick();
      case (k)
        1042: check("pu_stage_1042", 32'(rst_stage), 32'hF);
        1043: check("pu_stage_1043", 32'(rst_stage), 32'hE);
        1059: check("pu_stage_1059", 32'(rst_stage), 32'hC);
        1075: check("pu_stage_1075", 32'(rst_stage), 32'h8);
        1090: check("pu_done_1090", 32'(seq_done), 32'd0);
        1091: begin
          check("pu_stage_1091", 32'(rst_stage), 32'h0);
          check("pu_done_1091", 32'(seq_done), 32'd1);
        end
        default: ;
      endcase
    end

    // Reset out of RUN, then a one-cycle lock glitch during qualification.
    sys_rst = 1'b1; tick(); check_reset_vals("rst_run");
    sys_rst = 1'b0;
    for (int k = 0; k <= 1600; k++) begin
      if (k == 500) mmc_lock = 1'b0;
      if (k == 501) mmc_lock = 1'b1;
      tick();
      if (k == 1043) check("gl_no_early", 32'(rst_stage), 32'hF);
      if (k == 1542) check("gl_stage0_hold", 32'(rst_stage[0]), 32'd1);
      if (k == 1543) check("gl_stage0_rel", 32'(rst_stage[0]), 32'd1);
      if (k == 1544) check("gl_stage0_clr", 32'(rst_stage[0]), 32'd0);
    end

    // Lock loss in RUN, then restore.
    mmc_lock = 1'b0;
    repeat (3) tick();
    check("ll_stage", 32'(rst_stage), 32'hF);
    check("ll_done", 32'(seq_done), 32'd0);
    check("ll_state", 32'(seq_state), 32'd0);
    check("ll_cnt", 32'(lock_lost_cnt), CNT_EN ? 32'd1 : 32'd0);
    mmc_lock = 1'b1;
    for (int k = 0; k <= 1095; k++) begin
      tick();
      if (k == 1091) check("ll_resequence", 32'(seq_done), 32'd1);
    end

    // Soft reset pulse in RUN.
    soft_rst_req = 1'b1; tick(); soft_rst_req = 1'b0;
    check("sr_stage", 32'(rst_stage), 32'hF);
    check("sr_state", 32'(seq_state), 32'd4);
    for (int k = 1; k <= 64 + 1089; k++) begin
      tick();
      if (k == 63) check("sr_hold", 32'(seq_state), 32'd4);
      if (k == 64) check("sr_wait", 32'(seq_state), 32'd0);
      if (k == 64 + 1088) check("sr_done_pre", 32'(seq_done), 32'd0);
      if (k == 64 + 1089) check("sr_done", 32'(seq_done), 32'd1);
    end

    // Simultaneous lock loss and soft request in RELEASE after stage 1 released.
    sys_rst = 1'b1; tick(); sys_rst = 1'b0;
    for (int k = 0; k <= 1063; k++) begin
      if (k == 1061) mmc_lock = 1'b0;
      soft_rst_req = (k == 1063);
      tick();
      if (k == 1060) check("sim_pre_stage", 32'(rst_stage), 32'hC);
    end
    soft_rst_req = 1'b0;
    check("sim_state", 32'(seq_state), 32'd0);
    check("sim_stage", 32'(rst_stage), 32'hF);
    check("sim_cnt", 32'(lock_lost_cnt), CNT_EN ? 32'd1 : 32'd0);
    repeat (4) tick();

    // sys_rst in the middle of RELEASE.
    mmc_lock = 1'b1;
    repeat (1070) tick();
    check("mr_pre_state", 32'(seq_state), 32'd2);
    sys_rst = 1'b1; tick(); check_reset_vals("mid_rel");
    sys_rst = 1'b0;

    // Randomized traffic against the model.
    for (int k = 0; k < 15000; k++) begin
      if (mmc_lock) mmc_lock = ($urandom_range(0, 2499) != 0);
      else          mmc_lock = ($urandom_range(0, 3) == 0);
      soft_rst_req = ($urandom_range(0, 599) == 0);
      sys_rst      = ($urandom_range(0, 7999) == 0);
      tick();
    end
    sys_rst = 1'b0; soft_rst_req = 1'b0; mmc_lock = 1'b1;

    // 300 forced lock losses on the small instance.
    sm_rst = 1'b1; tick(); sm_rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      sm_lock = 1'b1;
      repeat (12) tick();
      check("sm_done_up", 32'(sm_done), 32'd1);
      check("sm_stage_up", 32'(sm_stage), 32'd0);
      sm_lock = 1'b0;
      repeat (3) tick();
      exp_sm = (i + 1 > 255) ? 255 : i + 1;
      check("sm_stage_dn", 32'(sm_stage), 32'h3);
      check("sm_lost_cnt", 32'(sm_cnt), CNT_EN ? 32'(exp_sm) : 32'd0);
    end
    check("sm_cnt_final", 32'(sm_cnt), CNT_EN ? 32'd255 : 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
